// File: rtl/acc_pkg.sv
// Shared encodings and width helper for the sign-magnitude group accumulator.
package acc_pkg;

    localparam int RND_HALF_UP = 0;
    localparam int RND_TRUNC   = 1;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

    // Magnitude width that can absorb LEN full-scale terms without overflow.
    function automatic int acc_width(input int mag_w, input int frac_w, input int len);
        return mag_w + frac_w + $clog2(len);
    endfunction

endpackage

// File: rtl/sm_add.sv
// Combinational sign-magnitude adder: larger magnitude sets the sign, zero is always +0.
module sm_add #(
    parameter int N = 8
) (
    input  logic         a_sgn,
    input  logic [N-1:0] a_mag,
    input  logic         b_sgn,
    input  logic [N-1:0] b_mag,
    output logic         s_sgn,
    output logic [N-1:0] s_mag
);

    logic         a_ge;
    logic         sub;
    logic [N-1:0] hi_mag;
    logic [N-1:0] lo_mag;
    logic [N-1:0] opnd;
    logic [N-1:0] sum;

    always_comb begin
        a_ge   = (a_mag >= b_mag);
        sub    = a_sgn ^ b_sgn;
        hi_mag = a_ge ? a_mag : b_mag;
        lo_mag = a_ge ? b_mag : a_mag;
        // Subtraction as hi + ~lo + 1; hi >= lo so the result never goes negative.
        opnd   = sub ? ~lo_mag : lo_mag;
        sum    = hi_mag + opnd + N'(sub);
        s_mag  = sum;
        s_sgn  = (a_ge ? a_sgn : b_sgn) & (|sum);
    end

endmodule

// File: rtl/acc_sm_seq.sv
// Accumulates sign-magnitude terms into groups, then rounds, saturates and holds
// each group result under a valid/ready handshake.
module acc_sm_seq
    import acc_pkg::*;
#(
    parameter int MAG_W  = 7,
    parameter int FRAC_W = 1,
    parameter int LEN    = 16,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sgn,
    input  logic [MAG_W+FRAC_W-1:0] in_mag,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sgn,
    output logic [MAG_W-1:0]        out_mag,
    output logic                    out_ovf
);

    localparam int IN_W     = MAG_W + FRAC_W;
    localparam int ACC_W    = acc_width(MAG_W, FRAC_W, LEN);
    localparam int CNT_W    = $clog2(LEN);
    localparam int RND_MODE = RND_HALF_UP;
    localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W - 1);

    function automatic logic [ACC_W:0] round_mag(input logic [ACC_W-1:0] mag);
        logic [ACC_W:0] ext;
        ext = {1'b0, mag};
        if (RND_MODE == RND_HALF_UP) begin
            ext = ext + HALF;
        end
        return ext >> FRAC_W;
    endfunction

    // Returns {overflow, magnitude}; clamps to full scale or keeps the low bits.
    function automatic logic [MAG_W:0] sat_mag(input logic [ACC_W:0] rnd);
        logic             ovf;
        logic [MAG_W-1:0] mag;
        ovf = |rnd[ACC_W:MAG_W];
        mag = rnd[MAG_W-1:0];
        if (ovf && (SAT == SAT_CLAMP)) begin
            mag = '1;
        end
        return {ovf, mag};
    endfunction

    acc_state_e       state_q, state_d;
    logic             acc_sgn_q, acc_sgn_d;
    logic [ACC_W-1:0] acc_mag_q, acc_mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_sgn_q, out_sgn_d;
    logic [MAG_W-1:0] out_mag_q, out_mag_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] term_mag;
    logic             sum_sgn;
    logic [ACC_W-1:0] sum_mag;
    logic [ACC_W:0]   rnd;
    logic [MAG_W:0]   res;
    logic             close_grp;

    assign term_mag = {{(ACC_W - IN_W){1'b0}}, in_mag};

    sm_add #(.N(ACC_W)) u_add (
        .a_sgn (acc_sgn_q),
        .a_mag (acc_mag_q),
        .b_sgn (in_sgn),
        .b_mag (term_mag),
        .s_sgn (sum_sgn),
        .s_mag (sum_mag)
    );

    assign rnd       = round_mag(sum_mag);
    assign res       = sat_mag(rnd);
    assign close_grp = in_last || (cnt_q == CNT_W'(LEN - 1));

    always_comb begin
        state_d   = state_q;
        acc_sgn_d = acc_sgn_q;
        acc_mag_d = acc_mag_q;
        cnt_d     = cnt_q;
        out_sgn_d = out_sgn_q;
        out_mag_d = out_mag_q;
        out_ovf_d = out_ovf_q;
        unique case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    if (close_grp) begin
                        state_d   = ST_HOLD;
                        acc_sgn_d = 1'b0;
                        acc_mag_d = '0;
                        cnt_d     = '0;
                        out_mag_d = res[MAG_W-1:0];
                        out_ovf_d = res[MAG_W];
                        // Rounding or wrap can reach zero; never present -0.
                        out_sgn_d = sum_sgn & (|res[MAG_W-1:0]);
                    end else begin
                        acc_sgn_d = sum_sgn;
                        acc_mag_d = sum_mag;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_sgn_q <= 1'b0;
            acc_mag_q <= '0;
            cnt_q     <= '0;
            out_sgn_q <= 1'b0;
            out_mag_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_sgn_q <= acc_sgn_d;
            acc_mag_q <= acc_mag_d;
            cnt_q     <= cnt_d;
            out_sgn_q <= out_sgn_d;
            out_mag_q <= out_mag_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sgn   = out_sgn_q;
    assign out_mag   = out_mag_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/acc_sm_seq.md
ACC_SM_SEQ -- requirements
Module: acc_sm_seq

Interface
REQ-001 SHALL have parameter MAG_W, default 7: output magnitude width in bits; the output sign bit is separate.
REQ-002 SHALL have parameter FRAC_W, default 1: extra fractional LSBs carried on each input term (FRAC_W >= 1).
REQ-003 SHALL have parameter LEN, default 16: maximum terms per group (LEN >= 2).
REQ-004 SHALL have parameter SAT, default 1: 1 = saturate on output overflow, 0 = wrap.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  input term valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-009 SHALL have port in_sgn  input  1  term sign, 1 = negative.
REQ-010 SHALL have port in_mag  input  MAG_W+FRAC_W  term magnitude, unsigned with FRAC_W fractional bits.
REQ-011 SHALL have port in_last  input  1  term closes the current group.
REQ-012 SHALL have port out_valid  output  1  group result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_sgn  output  1  result sign.
REQ-015 SHALL have port out_mag  output  MAG_W  result magnitude, integer.
REQ-016 SHALL have port out_ovf  output  1  rounded magnitude exceeded 2^MAG_W-1.

Function
REQ-017 SHALL implement a two-state FSM: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 SHALL accept a term only on a cycle with in_valid & in_ready.
REQ-019 SHALL hold an internal sign-magnitude accumulator: sign bit plus ACC_W = MAG_W+FRAC_W+clog2(LEN) magnitude bits; no internal overflow is possible.
REQ-020 SHALL add each accepted term exactly: equal signs add magnitudes; unequal signs give |difference| with the sign of the larger operand.
REQ-021 SHALL force the sign to 0 whenever the magnitude is 0 (no negative zero), both internally and at the output.
REQ-022 SHALL close a group on the accepted beat with in_last=1, or on the LEN-th accepted beat, whichever comes first.
REQ-023 SHALL register the group result on the closing beat; out_valid SHALL rise on the next cycle (latency 1 from the closing beat).
REQ-024 SHALL round the final magnitude half-up on its FRAC_W bits, i.e. ties away from zero (add 2^(FRAC_W-1), then drop FRAC_W bits).
REQ-025 SHALL, when the rounded magnitude exceeds 2^MAG_W-1, set out_ovf=1 and output 2^MAG_W-1 if SAT=1, or the low MAG_W bits if SAT=0.
REQ-026 SHALL clear the accumulator and beat counter when a group closes; the next group starts from +0.
REQ-027 SHALL hold out_sgn, out_mag and out_ovf stable in HOLD until out_valid & out_ready, then return to ACC on the next cycle; there is no bypass, so there is one idle input cycle per group.
REQ-028 SHALL ignore in_valid, in_last and the input data while in HOLD.

Reset
REQ-029 SHALL, with rst high at a clock edge, set the state to ACC, the accumulator to +0, the beat counter to 0, out_valid=0, out_sgn=0, out_mag=0 and out_ovf=0.
REQ-030 SHALL discard any partial group or pending result on reset; rst takes priority over any simultaneous handshake.

Structure
REQ-031 SHALL take the rounding-mode and saturation-mode encodings and a helper function for ACC_W from the shared package acc_pkg.
REQ-032 SHALL instantiate one sub-module, sm_add: a parametrised combinational sign-magnitude adder (width N, magnitude compare, conditional invert, carry-in) that returns sign and magnitude with the zero-sign fix.
REQ-033 SHALL keep the FSM, beat counter, rounding and saturation logic in acc_sm_seq.

Verification (MAG_W=7, FRAC_W=1, LEN=4 unless stated)
REQ-034 SHALL cover a single term: +9 (4.5) with in_last -> next cycle out_valid=1, out_sgn=0, out_mag=5, out_ovf=0.
REQ-035 SHALL cover a mixed-sign group: +20, then -7 with in_last -> internal +13 (6.5) -> out_sgn=0, out_mag=7.
REQ-036 SHALL cover cancellation: +6, then -6 with in_last -> out_sgn=0, out_mag=0 (no negative zero).
REQ-037 SHALL cover a LEN-terminated group with saturation: four beats of +255 and in_last=0 -> group closes after beat 4; out_mag=127, out_ovf=1; with SAT=0, out_mag=510 mod 128=126 and out_ovf=1.
REQ-038 SHALL cover backpressure: out_ready held low for 3 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout; the first beat is accepted the cycle after the handshake.
REQ-039 SHALL cover reset mid-group: rst after 2 of 3 beats -> out_valid=0; a following group of -3 (1.5) with in_last gives out_sgn=1, out_mag=2.
